seg7_hex_reader: RTL

//  Inverse of the team's nibble->7-segment encoder. Samples NUM_DIGITS active-low

---
 rtl/seg7_hex_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg7_hex_reader.sv
// Reads back a bank of active-low 7-segment bytes: waits for the bank to settle,
// decodes each byte to its hex nibble and offers the word on a valid/ready handshake.
module seg7_hex_reader #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*NUM_DIGITS-1:0]   seg_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     bad_mask,
    output logic [NUM_DIGITS-1:0]     dp_mask
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        TRACK,
        DECODE,
        PRESENT
    } state_t;

    state_t                    r_state;
    logic [8*NUM_DIGITS-1:0]   r_snap;
    logic [8*NUM_DIGITS-1:0]   r_last;
    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic                      r_first;
    logic                      r_outValid;
    logic [4*NUM_DIGITS-1:0]   r_value;
    logic [NUM_DIGITS-1:0]     r_badMask;
    logic [NUM_DIGITS-1:0]     r_dpMask;

    logic [7:0]                w_curByte;
    logic [3:0]                w_nibble;
    logic                      w_bad;

    assign w_curByte = r_snap[8*r_idx +: 8];

    // Segment pattern to nibble; the decimal point is handled separately.
    always_comb begin
        w_nibble = 4'h0;
        w_bad    = 1'b0;
        case (w_curByte[6:0])
            7'h40:   w_nibble = 4'h0;
            7'h79:   w_nibble = 4'h1;
            7'h24:   w_nibble = 4'h2;
            7'h30:   w_nibble = 4'h3;
            7'h19:   w_nibble = 4'h4;
            7'h12:   w_nibble = 4'h5;
            7'h02:   w_nibble = 4'h6;
            7'h78:   w_nibble = 4'h7;
            7'h00:   w_nibble = 4'h8;
            7'h10:   w_nibble = 4'h9;
            7'h20:   w_nibble = 4'hA;
            7'h03:   w_nibble = 4'hB;
            7'h27:   w_nibble = 4'hC;
            7'h21:   w_nibble = 4'hD;
            7'h06:   w_nibble = 4'hE;
            7'h0E:   w_nibble = 4'hF;
            default: w_bad    = 1'b1;
        endcase
    end

    // A report is raised only once per distinct stable pattern; r_first forces the
    // very first one after reset even when the bank is blank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= TRACK;
            r_snap     <= '1;
            r_last     <= '1;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_first    <= 1'b1;
            r_outValid <= 1'b0;
            r_value    <= '0;
            r_badMask  <= '0;
            r_dpMask   <= '0;
        end else begin
            case (r_state)
                TRACK: begin
                    if (seg_in != r_snap) begin
                        r_snap <= seg_in;
                        r_cnt  <= CW'(1);
                    end else begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt == CNT_MAX && (r_snap != r_last || r_first)) begin
                            r_state <= DECODE;
                            r_idx   <= '0;
                        end
                    end
                end
                DECODE: begin
                    r_value[4*r_idx +: 4] <= w_nibble;
                    r_badMask[r_idx]      <= w_bad;
                    r_dpMask[r_idx]       <= ~w_curByte[7];
                    if (r_idx == IDX_LAST) begin
                        r_state    <= PRESENT;
                        r_outValid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_last     <= r_snap;
                        r_first    <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= TRACK;
                    end
                end
                default: begin
                    r_state <= TRACK;
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign value     = r_value;
    assign bad_mask  = r_badMask;
    assign dp_mask   = r_dpMask;

endmodule
